// File: rtl/mips_funct_pkg.sv
// Shared funct codes, writeback-select FSM state and class decode for the MIPS-subset datapath.
package mips_funct_pkg;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULTU = 6'b011001;

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_WAIT = 1'b1
    } state_t;

    function automatic logic is_hilo(input logic [5:0] f);
        return (f == F_MFHI) || (f == F_MFLO) || (f == F_MTHI) ||
               (f == F_MTLO) || (f == F_MULTU);
    endfunction

endpackage

// File: rtl/hilo_regs.sv
// Hi/Lo register pair: 1-cycle write, full product load or single-half MTHI/MTLO load.
// No backpressure; the caller's FSM keeps the two write sources mutually exclusive.
module hilo_regs #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               prod_ld,
    input  logic [2*WIDTH-1:0] prod,
    input  logic               hi_ld,
    input  logic               lo_ld,
    input  logic [WIDTH-1:0]   wdat,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (prod_ld) begin
            r_hi <= prod[2*WIDTH-1:WIDTH];
            r_lo <= prod[WIDTH-1:0];
        end else begin
            if (hi_ld) r_hi <= wdat;
            if (lo_ld) r_lo <= wdat;
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

    ap_no_collide: assert property (@(posedge clk) disable iff (reset)
        !(prod_ld && (hi_ld || lo_ld)));

endmodule

// File: rtl/result_select_hilo.sv
// Writeback select with Hi/Lo ownership: decodes funct, registers result 1 cycle after accept.
// op_ready drops only for HiLo-class ops while a MULTU is outstanding; ALU/shift ops flow past.
module result_select_hilo
    import mips_funct_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int FUNCT_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [WIDTH-1:0]   alu_out,
    input  logic [WIDTH-1:0]   shft_out,
    input  logic               prod_valid,
    input  logic [2*WIDTH-1:0] prod,
    output logic               res_valid,
    output logic [WIDTH-1:0]   res,
    output logic               illegal,
    output logic               mul_pending,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_res;
    logic             r_res_valid;
    logic             r_illegal;

    logic [5:0]       w_code;
    logic             w_code_ok;
    logic             w_hilo_op;
    logic             w_accept;
    logic             w_prod_ld;
    logic             w_res_ld;
    logic             w_ill;
    logic             w_hi_ld;
    logic             w_lo_ld;
    logic             w_multu;
    logic [WIDTH-1:0] w_res_nxt;
    logic [WIDTH-1:0] w_hi;
    logic [WIDTH-1:0] w_lo;

    // Codes wider than 6 bits are only legal when the extra upper bits are zero.
    assign w_code    = funct[5:0];
    assign w_code_ok = ((funct >> 6) == '0);
    assign w_hilo_op = w_code_ok && is_hilo(w_code);

    assign op_ready  = (r_state == IDLE) || !w_hilo_op;
    assign w_accept  = op_valid && op_ready;
    assign w_prod_ld = (r_state == MUL_WAIT) && prod_valid;

    always_comb begin
        w_res_nxt = '0;
        w_res_ld  = 1'b0;
        w_ill     = 1'b0;
        w_hi_ld   = 1'b0;
        w_lo_ld   = 1'b0;
        w_multu   = 1'b0;
        if (!w_code_ok) begin
            w_res_ld = 1'b1;
            w_ill    = 1'b1;
        end else begin
            case (w_code)
                F_ADD, F_SUB, F_AND, F_OR, F_SLT: begin
                    w_res_nxt = alu_out;
                    w_res_ld  = 1'b1;
                end
                F_SRL: begin
                    w_res_nxt = shft_out;
                    w_res_ld  = 1'b1;
                end
                F_MFHI: begin
                    w_res_nxt = w_hi;
                    w_res_ld  = 1'b1;
                end
                F_MFLO: begin
                    w_res_nxt = w_lo;
                    w_res_ld  = 1'b1;
                end
                F_MTHI:  w_hi_ld = 1'b1;
                F_MTLO:  w_lo_ld = 1'b1;
                F_MULTU: w_multu = 1'b1;
                default: begin
                    w_res_ld = 1'b1;
                    w_ill    = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:     if (w_accept && w_multu) w_state_nxt = MUL_WAIT;
            MUL_WAIT: if (prod_valid)          w_state_nxt = IDLE;
            default:                           w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_res       <= '0;
            r_res_valid <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_res_valid <= w_accept && w_res_ld;
            r_illegal   <= w_accept && w_ill;
            if (w_accept && w_res_ld) r_res <= w_res_nxt;
        end
    end

    hilo_regs #(.WIDTH(WIDTH)) u_hilo_regs (
        .clk     (clk),
        .reset   (reset),
        .prod_ld (w_prod_ld),
        .prod    (prod),
        .hi_ld   (w_accept && w_hi_ld),
        .lo_ld   (w_accept && w_lo_ld),
        .wdat    (alu_out),
        .hi      (w_hi),
        .lo      (w_lo)
    );

    assign res_valid   = r_res_valid;
    assign res         = r_res;
    assign illegal     = r_illegal;
    assign mul_pending = (r_state == MUL_WAIT);
    assign hi          = w_hi;
    assign lo          = w_lo;

endmodule

// File: tb/tb_result_select_hilo.sv
// Bench for result_select_hilo: directed literal scenarios plus random traffic against an op-level model.
module tb_result_select_hilo;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic        op_ready;
    logic [5:0]  funct;
    logic [31:0] alu_out;
    logic [31:0] shft_out;
    logic        prod_valid;
    logic [63:0] prod;
    logic        res_valid;
    logic [31:0] res;
    logic        illegal;
    logic        mul_pending;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model state: architectural view of what the stage must expose.
    logic [31:0] m_hi, m_lo, m_res;
    bit          m_pend, m_rv, m_ill;

    localparam logic [5:0] C_ADD = 6'b100000, C_SUB = 6'b100010, C_AND = 6'b100100,
                           C_OR = 6'b100101, C_SLT = 6'b101010, C_SRL = 6'b000010,
                           C_MFHI = 6'b010000, C_MTHI = 6'b010001, C_MFLO = 6'b010010,
                           C_MTLO = 6'b010011, C_MULTU = 6'b011001;

    always #5 clk = ~clk;

    result_select_hilo #(.WIDTH(32), .FUNCT_W(6)) dut (
        .clk         (clk),
        .reset       (reset),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .funct       (funct),
        .alu_out     (alu_out),
        .shft_out    (shft_out),
        .prod_valid  (prod_valid),
        .prod        (prod),
        .res_valid   (res_valid),
        .res         (res),
        .illegal     (illegal),
        .mul_pending (mul_pending),
        .hi          (hi),
        .lo          (lo)
    );

    function automatic bit hilo_class(input logic [5:0] f);
        return f inside {C_MFHI, C_MFLO, C_MTHI, C_MTLO, C_MULTU};
    endfunction

    function automatic bit model_ready(input logic [5:0] f);
        return !m_pend || !hilo_class(f);
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: advances once per rising edge from the inputs presented for that edge.
    always @(posedge clk) begin
        logic [31:0] n_hi, n_lo;
        bit          n_pend;
        if (reset) begin
            m_hi = '0; m_lo = '0; m_res = '0;
            m_pend = 0; m_rv = 0; m_ill = 0;
        end else begin
            n_hi = m_hi; n_lo = m_lo; n_pend = m_pend;
            m_rv = 0; m_ill = 0;
            if (m_pend && prod_valid) begin
                n_hi = prod[63:32];
                n_lo = prod[31:0];
                n_pend = 0;
            end
            if (op_valid && model_ready(funct)) begin
                if (funct inside {C_ADD, C_SUB, C_AND, C_OR, C_SLT}) begin
                    m_res = alu_out; m_rv = 1;
                end else if (funct == C_SRL) begin
                    m_res = shft_out; m_rv = 1;
                end else if (funct == C_MFHI) begin
                    m_res = m_hi; m_rv = 1;
                end else if (funct == C_MFLO) begin
                    m_res = m_lo; m_rv = 1;
                end else if (funct == C_MTHI) begin
                    n_hi = alu_out;
                end else if (funct == C_MTLO) begin
                    n_lo = alu_out;
                end else if (funct == C_MULTU) begin
                    n_pend = 1;
                end else begin
                    m_res = '0; m_rv = 1; m_ill = 1;
                end
            end
            m_hi = n_hi; m_lo = n_lo; m_pend = n_pend;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("res_valid", 64'(res_valid), 64'(m_rv));
            cmp("res", 64'(res), 64'(m_res));
            cmp("illegal", 64'(illegal), 64'(m_ill));
            cmp("mul_pending", 64'(mul_pending), 64'(m_pend));
            cmp("hi", 64'(hi), 64'(m_hi));
            cmp("lo", 64'(lo), 64'(m_lo));
            cmp("op_ready", 64'(op_ready), 64'(model_ready(funct)));
        end
    end

    task automatic drv(input bit v, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] s, input bit pv, input logic [63:0] p);
        op_valid = v; funct = f; alu_out = a; shft_out = s; prod_valid = pv; prod = p;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drv(0, C_ADD, 0, 0, 0, 0);
        tick;
        chk_en = 1'b1;
        tick;
        cmp("rst_res", 64'(res), 64'h0);
        cmp("rst_res_valid", 64'(res_valid), 64'h0);
        cmp("rst_mul_pending", 64'(mul_pending), 64'h0);
        cmp("rst_hi", 64'(hi), 64'h0);
        cmp("rst_lo", 64'(lo), 64'h0);
        reset = 1'b0;

        drv(1, C_ADD, 32'h0000_0005, 32'h0, 0, 0); tick;
        cmp("add_res", 64'(res), 64'h5);
        cmp("add_valid", 64'(res_valid), 64'h1);
        drv(1, C_SRL, 32'h0, 32'h8000_0000, 0, 0); tick;
        cmp("srl_res", 64'(res), 64'h8000_0000);
        drv(0, C_ADD, 32'h1111, 32'h0, 0, 0); tick;
        cmp("idle_valid", 64'(res_valid), 64'h0);
        cmp("idle_hold", 64'(res), 64'h8000_0000);

        drv(1, C_MTHI, 32'hDEAD_BEEF, 32'h0, 0, 0); tick;
        cmp("mthi_novalid", 64'(res_valid), 64'h0);
        drv(1, C_MFHI, 32'h0, 32'h0, 0, 0);
        cmp("mfhi_ready", 64'(op_ready), 64'h1);
        tick;
        cmp("mfhi_res", 64'(res), 64'hDEAD_BEEF);
        drv(1, C_MTLO, 32'h0000_1234, 32'h0, 0, 0); tick;
        drv(1, C_MFLO, 32'h0, 32'h0, 0, 0); tick;
        cmp("mflo_res", 64'(res), 64'h1234);

        drv(1, C_MULTU, 32'h0, 32'h0, 0, 0); tick;
        cmp("multu_pending", 64'(mul_pending), 64'h1);
        drv(1, C_MFHI, 32'h0, 32'h0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cmp("stall_ready", 64'(op_ready), 64'h0);
            tick;
            cmp("stall_novalid", 64'(res_valid), 64'h0);
        end
        drv(1, C_MFHI, 32'h0, 32'h0, 1, 64'h0000_0001_FFFF_FFFE);
        cmp("pv_cycle_ready", 64'(op_ready), 64'h0);
        tick;
        cmp("prod_hi", 64'(hi), 64'h1);
        cmp("prod_lo", 64'(lo), 64'hFFFF_FFFE);
        cmp("prod_pending", 64'(mul_pending), 64'h0);
        drv(1, C_MFHI, 32'h0, 32'h0, 0, 0);
        cmp("post_ready", 64'(op_ready), 64'h1);
        tick;
        cmp("post_mfhi", 64'(res), 64'h1);
        drv(1, C_MFLO, 32'h0, 32'h0, 0, 0); tick;
        cmp("post_mflo", 64'(res), 64'hFFFF_FFFE);

        drv(1, C_MULTU, 32'h0, 32'h0, 0, 0); tick;
        drv(1, C_ADD, 32'h7, 32'h0, 0, 0);
        cmp("wait_add_ready", 64'(op_ready), 64'h1);
        tick;
        cmp("wait_add_res", 64'(res), 64'h7);
        drv(1, C_SLT, 32'h1, 32'h0, 0, 0); tick;
        cmp("wait_slt_res", 64'(res), 64'h1);
        cmp("wait_pending", 64'(mul_pending), 64'h1);
        drv(0, C_ADD, 32'h0, 32'h0, 1, 64'hAAAA_AAAA_5555_5555); tick;
        cmp("prod2_hi", 64'(hi), 64'hAAAA_AAAA);

        drv(1, 6'b111111, 32'h55, 32'h66, 0, 0); tick;
        cmp("ill_res", 64'(res), 64'h0);
        cmp("ill_valid", 64'(res_valid), 64'h1);
        cmp("ill_flag", 64'(illegal), 64'h1);
        drv(0, C_ADD, 32'h0, 32'h0, 1, 64'h0123_4567_89AB_CDEF); tick;
        cmp("ill_pulse", 64'(illegal), 64'h0);
        cmp("idle_pv_hi", 64'(hi), 64'hAAAA_AAAA);
        cmp("idle_pv_lo", 64'(lo), 64'h5555_5555);

        drv(1, C_MULTU, 32'h0, 32'h0, 0, 0); tick;
        cmp("pre_rst_pending", 64'(mul_pending), 64'h1);
        reset = 1'b1;
        drv(0, C_ADD, 32'h0, 32'h0, 0, 0); tick;
        reset = 1'b0;
        cmp("rst_wait_pending", 64'(mul_pending), 64'h0);
        cmp("rst_wait_hi", 64'(hi), 64'h0);
        cmp("rst_wait_lo", 64'(lo), 64'h0);
        drv(0, C_ADD, 32'h0, 32'h0, 1, 64'hFFFF_FFFF_FFFF_FFFF); tick;
        cmp("late_pv_hi", 64'(hi), 64'h0);
        drv(1, C_MFHI, 32'h0, 32'h0, 0, 0);
        cmp("late_mfhi_ready", 64'(op_ready), 64'h1);
        tick;
        cmp("late_mfhi_res", 64'(res), 64'h0);
        cmp("late_mfhi_valid", 64'(res_valid), 64'h1);

        // Random traffic: legal and illegal codes, stalls, stray products and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            logic [5:0] f;
            case ($urandom_range(0, 11))
                0: f = C_ADD;   1: f = C_SUB;  2: f = C_AND;  3: f = C_OR;
                4: f = C_SLT;   5: f = C_SRL;  6: f = C_MFHI; 7: f = C_MFLO;
                8: f = C_MTHI;  9: f = C_MTLO; 10: f = C_MULTU;
                default: f = 6'($urandom);
            endcase
            reset = ($urandom_range(0, 63) == 0);
            drv(($urandom_range(0, 9) < 7), f, $urandom, $urandom,
                ($urandom_range(0, 6) == 0), {$urandom, $urandom});
            tick;
        end
        reset = 1'b0;
        drv(0, C_ADD, 32'h0, 32'h0, 0, 0);
        tick;
        chk_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_select_hilo.md
# result_select_hilo

Parametrised writeback-select stage for the MIPS-subset datapath: a successor to the purely combinational ALU/shifter/Hi/Lo output mux. It decodes the R-type `funct` field and registers the selected result for writeback. It owns the Hi/Lo register pair, loaded from an external multiplier's product or by MTHI/MTLO. It also stalls Hi/Lo reads and writes while a MULTU is outstanding.

## Interface
- `WIDTH`, 32: datapath width; Hi/Lo and result width.
- `FUNCT_W`, 6: width of `funct`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `op_valid` in 1: an operation is presented this cycle.
- `op_ready` out 1: the operation is accepted this cycle when `op_valid & op_ready`.
- `funct` in FUNCT_W: operation code.
- `alu_out` in WIDTH: ALU result. It is also the source operand for MTHI/MTLO.
- `shft_out` in WIDTH: shifter result.
- `prod_valid` in 1: one-cycle pulse from the multiplier; `prod` is valid.
- `prod` in 2*WIDTH: product; upper half goes to Hi, lower half to Lo.
- `res_valid` out 1: registered pulse; `res` is valid.
- `res` out WIDTH: registered writeback data.
- `illegal` out 1: registered pulse; an accepted `funct` was unrecognised.
- `mul_pending` out 1: high while in MUL_WAIT.
- `hi`, `lo` out WIDTH: current Hi/Lo register contents.

## Operation
- Decode of `funct`:
  - ALU class: ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010. Result is `alu_out`.
  - Shift class: SRL 000010. Result is `shft_out`.
  - MFHI 010000 returns `hi`. MFLO 010010 returns `lo`.
  - MTHI 010001 loads `hi`←`alu_out`. MTLO 010011 loads `lo`←`alu_out`. Neither produces `res_valid`.
  - MULTU 011001 produces no result and enters MUL_WAIT.
  - Any other code: `res`=0, `res_valid`=1, `illegal`=1.
- "HiLo class" means MFHI, MFLO, MTHI, MTLO and MULTU.
- State machine:
  - IDLE → MUL_WAIT on an accepted MULTU.
  - MUL_WAIT → IDLE on `prod_valid`. In that cycle `hi`←`prod[2W-1:W]` and `lo`←`prod[W-1:0]`.
- `op_ready`:
  - Always 1 in IDLE.
  - In MUL_WAIT, 0 when `funct` is HiLo class; 1 otherwise. ALU and shift ops flow past a pending multiply.
  - `op_ready` is combinational from state and `funct`. It does not depend on `prod_valid`, so a stalled HiLo op is accepted no earlier than the cycle after `prod_valid`.
- `prod_valid` in IDLE is ignored; Hi/Lo are unchanged.
- Reset: state=IDLE, `hi`=`lo`=0, `res`=0, `res_valid`=0, `illegal`=0, `mul_pending`=0.
- Reset during MUL_WAIT abandons the multiply. A `prod_valid` arriving after reset is ignored.
- Reset has priority over all simultaneous events.

## Timing
- Result latency is 1 cycle: accept in cycle N, `res`/`res_valid` in N+1.
- `res` holds its last value when `res_valid`=0.
- MTHI/MTLO accepted in N: `hi`/`lo` updated in N+1. An MFHI accepted in N+1 returns the new value (no forwarding hazard).
- MULTU accepted in N: `mul_pending`=1 from N+1.
- `prod_valid` in M: `hi`/`lo` updated and `mul_pending`=0 from M+1. An MFHI accepted in M+1 returns the new Hi in M+2.
- Throughput is one op per cycle when not stalled.
- `op_valid`=0 produces no state change except the `prod_valid` capture.

## Structure
- Shared package `mips_funct_pkg`:
  - `localparam` funct codes above: AND, OR, ADD, SUB, SLT, SRL, MFHI, MFLO, MTHI, MTLO, MULTU.
  - State enum `{IDLE, MUL_WAIT}`.
  - Class-decode function `is_hilo(funct)`.
- Sub-module `hilo_regs`:
  - Holds the Hi/Lo pair with synchronous reset.
  - Write ports: product load (both halves) and single-half load (MTHI/MTLO).
  - The FSM guarantees the two write sources never coincide; assert this in simulation.

## Test plan
- Reset: after reset, ADD with `alu_out`=0x0000_0005 → `res`=0x5 and `res_valid` 1 cycle after accept. SRL with `shft_out`=0x8000_0000 → `res`=0x8000_0000.
- MTHI `alu_out`=0xDEAD_BEEF, then MFHI on the next cycle → `res`=0xDEAD_BEEF, no stall. MTLO 0x1234 then MFLO → `res`=0x1234.
- MULTU accepted → `mul_pending`=1. MFHI presented and `op_ready`=0 for all cycles until `prod_valid`. With `prod`=0x0000_0001_FFFF_FFFE, MFHI is accepted the cycle after `prod_valid` and returns `res`=0x1. A following MFLO returns 0xFFFF_FFFE.
- During MUL_WAIT, ADD and SLT keep `op_ready`=1 and return results with 1-cycle latency; `mul_pending` stays 1.
- `funct`=111111 accepted → `res`=0, `res_valid`=1, `illegal`=1 for one cycle. `prod_valid` pulsed in IDLE → `hi`/`lo` unchanged.
- Reset asserted mid MUL_WAIT → `mul_pending`=0, `hi`=`lo`=0. A subsequent `prod_valid` is ignored; MFHI returns 0 with no stall.
